// File: rtl/alu_seq16_pkg.sv
// Shared types for the 16-bit sequenced ALU: request opcodes, FSM states,
// 8-bit ALU opcodes and flag bit positions.
package alu_seq16_pkg;

   typedef enum logic [2:0] {
      OP_ADD16 = 3'd0,
      OP_SUB16 = 3'd1,
      OP_INC16 = 3'd2,
      OP_DEC16 = 3'd3,
      OP_CMP16 = 3'd4
   } seq16_op_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOW  = 3'd1,
      ST_HIGH = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_INC = 2'd2,
      ALU_DEC = 2'd3
   } alu_op_t;

   localparam int FLAG_S  = 7;
   localparam int FLAG_Z  = 6;
   localparam int FLAG_H  = 4;
   localparam int FLAG_PV = 2;
   localparam int FLAG_N  = 1;
   localparam int FLAG_C  = 0;

   // CMP16 always runs the subtract sequence, with or without the CMP feature.
   function automatic logic is_sub_op(input seq16_op_t op);
      return (op == OP_SUB16) || (op == OP_DEC16) || (op == OP_CMP16);
   endfunction

endpackage

// File: rtl/alu_seq16_if.sv
// Request/response bus of alu_seq16. Both channels use valid/ready: a transfer
// happens on a rising edge where valid and ready are both high.
interface alu_seq16_if;
   import alu_seq16_pkg::*;

   logic        req_valid;
   logic        req_ready;
   seq16_op_t   req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [7:0]  rsp_flags;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags
   );
endinterface

// File: rtl/alu_seq16_alu.sv
// Combinational narrow ALU (ADD/SUB/INC/DEC). Outputs are forced to zero while
// en is low. Carry in flag bit 0 is the borrow for subtracts.
module alu
   import alu_seq16_pkg::*;
#(
   parameter int alu_width = 8
) (
   input  logic                 en,
   input  alu_op_t              op,
   input  logic [alu_width-1:0] a,
   input  logic [alu_width-1:0] b,
   output logic [alu_width-1:0] result,
   output logic [7:0]           flags
);

   localparam int HALF = alu_width / 2;

   logic [alu_width:0]   sum;
   logic [HALF:0]        half;
   logic [alu_width-1:0] opb;
   logic                 sub;

   always_comb begin
      sum    = '0;
      half   = '0;
      opb    = '0;
      sub    = 1'b0;
      result = '0;
      flags  = '0;
      if (en) begin
         sub = (op == ALU_SUB) || (op == ALU_DEC);
         opb = ((op == ALU_INC) || (op == ALU_DEC)) ? alu_width'(1) : b;
         if (sub) begin
            sum  = {1'b0, a} - {1'b0, opb};
            half = {1'b0, a[HALF-1:0]} - {1'b0, opb[HALF-1:0]};
         end else begin
            sum  = {1'b0, a} + {1'b0, opb};
            half = {1'b0, a[HALF-1:0]} + {1'b0, opb[HALF-1:0]};
         end
         result          = sum[alu_width-1:0];
         flags[FLAG_S]   = result[alu_width-1];
         flags[FLAG_Z]   = (result == '0);
         flags[FLAG_H]   = half[HALF];
         flags[FLAG_PV]  = sub ? ((a[alu_width-1] != opb[alu_width-1]) && (result[alu_width-1] != a[alu_width-1]))
                               : ((a[alu_width-1] == opb[alu_width-1]) && (result[alu_width-1] != a[alu_width-1]));
         flags[FLAG_N]   = sub;
         flags[FLAG_C]   = sum[alu_width];
      end
   end

endmodule

// File: rtl/alu_seq16.sv
// 16-bit ADD/SUB/INC/DEC/CMP built from sequential passes through one 8-bit ALU.
// Optional feature macro ALU_SEQ16_CMP_EN: CMP16 returns operand a instead of a-b.
module alu_seq16
   import alu_seq16_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_seq16_if.slave   bus,
   output state_t       dbg_state
);

   state_t      state_q, state_d;
   seq16_op_t   op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] res_q, res_d;
   logic        c0_q, c0_d;
   logic        c1_q, c1_d;
   logic        h_q, h_d;
   logic        c_q, c_d;

   logic        alu_en;
   alu_op_t     alu_op_w;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_res;
   logic [7:0]  alu_flags;
   logic        fix_carry;
   logic        sub_q;
   logic [15:0] result_w;
   logic [7:0]  flags_w;
   logic        unused_alu_flags;

   alu #(.alu_width(8)) u_alu (
      .en     (alu_en),
      .op     (alu_op_w),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .flags  (alu_flags)
   );

   assign unused_alu_flags = ^{alu_flags[7:5], alu_flags[3:1]};
   assign sub_q            = is_sub_op(op_q);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      c0_d      = c0_q;
      c1_d      = c1_q;
      h_d       = h_q;
      c_d       = c_q;
      alu_en    = 1'b0;
      alu_op_w  = ALU_ADD;
      alu_a     = '0;
      alu_b     = '0;
      fix_carry = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               a_d     = bus.req_a;
               b_d     = ((bus.req_op == OP_INC16) || (bus.req_op == OP_DEC16)) ? 16'h0001 : bus.req_b;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            alu_en      = 1'b1;
            alu_op_w    = sub_q ? ALU_SUB : ALU_ADD;
            alu_a       = a_q[7:0];
            alu_b       = b_q[7:0];
            res_d[7:0]  = alu_res;
            c0_d        = alu_flags[FLAG_C];
            state_d     = ST_HIGH;
         end
         ST_HIGH: begin
            alu_en      = 1'b1;
            alu_op_w    = sub_q ? ALU_SUB : ALU_ADD;
            alu_a       = a_q[15:8];
            alu_b       = b_q[15:8];
            res_d[15:8] = alu_res;
            c1_d        = alu_flags[FLAG_C];
            c_d         = alu_flags[FLAG_C];
            h_d         = alu_flags[FLAG_H];
            state_d     = c0_q ? ST_FIX : ST_DONE;
         end
         ST_FIX: begin
            // The low-byte carry/borrow is folded into the high byte here.
            alu_en      = 1'b1;
            alu_op_w    = sub_q ? ALU_DEC : ALU_INC;
            alu_a       = res_q[15:8];
            fix_carry   = sub_q ? (res_q[15:8] == 8'h00) : (res_q[15:8] == 8'hFF);
            res_d[15:8] = alu_res;
            c_d         = c1_q | fix_carry;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_ADD16;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c0_q    <= 1'b0;
         c1_q    <= 1'b0;
         h_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         h_q     <= h_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      result_w = res_q;
`ifdef ALU_SEQ16_CMP_EN
      if (op_q == OP_CMP16) result_w = a_q;
`endif
      flags_w          = '0;
      flags_w[FLAG_S]  = res_q[15];
      flags_w[FLAG_Z]  = (res_q == 16'h0000);
      flags_w[FLAG_H]  = h_q;
      flags_w[FLAG_PV] = sub_q ? ((a_q[15] != b_q[15]) && (res_q[15] != a_q[15]))
                               : ((a_q[15] == b_q[15]) && (res_q[15] != a_q[15]));
      flags_w[FLAG_N]  = sub_q;
      flags_w[FLAG_C]  = c_q;
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.rsp_valid  = (state_q == ST_DONE);
   assign bus.rsp_result = (state_q == ST_DONE) ? result_w : 16'h0000;
   assign bus.rsp_flags  = (state_q == ST_DONE) ? flags_w : 8'h00;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed corner cases, back-pressure,
// mid-operation reset and randomized operations against a 16-bit arithmetic model.
module tb_alu_seq16;
   import alu_seq16_pkg::*;

`ifdef ALU_SEQ16_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic   clk;
   logic   rst_n;
   state_t dbg_state;
   int     n_checks;
   int     n_fail;
   logic [23:0] exp_q[$];
   logic [15:0] last_res;
   logic [7:0]  last_flags;

   alu_seq16_if bus ();

   alu_seq16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Plain 16-bit arithmetic; H is the nibble carry/borrow out of bits [11:8] of a op b.
   function automatic void ref_model(input seq16_op_t op, input logic [15:0] a, input logic [15:0] b_in,
                                     output logic [15:0] res, output logic [7:0] fl, output int lat);
      logic        sub;
      logic [15:0] b;
      logic [15:0] r;
      logic [16:0] s17;
      logic        c, h, pv, lowc;
      sub = (op == OP_SUB16) || (op == OP_DEC16) || (op == OP_CMP16);
      b   = ((op == OP_INC16) || (op == OP_DEC16)) ? 16'h0001 : b_in;
      if (sub) begin
         r    = a - b;
         c    = (a < b);
         h    = (a[11:8] < b[11:8]);
         pv   = (a[15] != b[15]) && (r[15] != a[15]);
         lowc = (a[7:0] < b[7:0]);
      end else begin
         s17  = {1'b0, a} + {1'b0, b};
         r    = s17[15:0];
         c    = s17[16];
         h    = ({1'b0, a[11:8]} + {1'b0, b[11:8]}) > 5'd15;
         pv   = (a[15] == b[15]) && (r[15] != a[15]);
         lowc = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
      end
      fl  = {r[15], (r == 16'h0000), 1'b0, h, 1'b0, pv, sub, c};
      res = (CMP_EN && op == OP_CMP16) ? a : r;
      // Edges counted including the acceptance edge.
      lat = lowc ? 4 : 3;
   endfunction

   task automatic run_op(input seq16_op_t op, input logic [15:0] a, input logic [15:0] b, input int hold);
      logic [15:0] er;
      logic [7:0]  ef;
      logic [23:0] exp;
      int          lat, exp_lat, waitc;
      bit          leak, stable;
      ref_model(op, a, b, er, ef, exp_lat);
      exp_q.push_back({er, ef});
      waitc = 0;
      while (!bus.req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      lat = 1;
      #1;
      bus.req_valid = 1'b0;
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      leak = 1'b0;
      @(negedge clk);
      while (!bus.rsp_valid && lat < 20) begin
         if (bus.rsp_result != 16'h0 || bus.rsp_flags != 8'h0 || bus.req_ready) leak = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("quiet_while_busy", leak, 0);
      check("latency", lat, exp_lat);
      exp = exp_q.pop_front();
      last_res   = bus.rsp_result;
      last_flags = bus.rsp_flags;
      check("result", bus.rsp_result, exp[23:8]);
      check("flags", bus.rsp_flags, exp[7:0]);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.rsp_valid || bus.req_ready || bus.rsp_result != exp[23:8] || bus.rsp_flags != exp[7:0])
            stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", stable, 1);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      check("idle_after_ready", {bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags}, {1'b0, 1'b1, 16'h0, 8'h0});
      @(negedge clk);
   endtask

   task automatic reset_in_high();
      int vcount;
      bus.req_valid = 1'b1;
      bus.req_op    = OP_ADD16;
      bus.req_a     = 16'h12FF;
      bus.req_b     = 16'h0001;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reached_high", dbg_state, ST_HIGH);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_req_ready", bus.req_ready, 1);
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) vcount++;
      end
      check("no_rsp_after_rst", vcount, 0);
   endtask

   initial begin
      seq16_op_t op;
      logic [15:0] a, b;
      logic [15:0] picks [5];
      n_checks = 0;
      n_fail   = 0;
      picks[0] = 16'h0000; picks[1] = 16'hFFFF; picks[2] = 16'h00FF;
      picks[3] = 16'h8000; picks[4] = 16'h7FFF;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = OP_ADD16;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      check("reset_outputs", {bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags}, {1'b0, 1'b1, 16'h0, 8'h0});
      check("reset_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(OP_ADD16, 16'h12FF, 16'h0001, 0);
      check("add_12ff_res", last_res, 16'h1300);
      check("add_12ff_czn", {last_flags[FLAG_C], last_flags[FLAG_Z], last_flags[FLAG_N]}, 3'b000);
      run_op(OP_ADD16, 16'hFFFF, 16'h0001, 0);
      check("add_ffff_res", last_res, 16'h0000);
      check("add_ffff_czspv", {last_flags[FLAG_C], last_flags[FLAG_Z], last_flags[FLAG_S], last_flags[FLAG_PV]}, 4'b1100);
      run_op(OP_ADD16, 16'h7FFF, 16'h0001, 0);
      check("add_7fff_res", last_res, 16'h8000);
      check("add_7fff_spvc", {last_flags[FLAG_S], last_flags[FLAG_PV], last_flags[FLAG_C]}, 3'b110);
      run_op(OP_SUB16, 16'h1000, 16'h0001, 0);
      check("sub_1000_res", last_res, 16'h0FFF);
      run_op(OP_SUB16, 16'h0000, 16'h0001, 0);
      check("sub_0000_res", last_res, 16'hFFFF);
      run_op(OP_SUB16, 16'h1234, 16'h0034, 0);
      run_op(OP_ADD16, 16'h4321, 16'h1111, 5);
      run_op(OP_CMP16, 16'h0005, 16'h0005, 0);
      check("cmp_res", last_res, CMP_EN ? 16'h0005 : 16'h0000);
      check("cmp_zn", {last_flags[FLAG_Z], last_flags[FLAG_N]}, 2'b11);
      run_op(OP_INC16, 16'hFFFF, 16'h5555, 1);
      run_op(OP_DEC16, 16'h0000, 16'hAAAA, 2);
      reset_in_high();
      run_op(OP_SUB16, 16'h8000, 16'h0001, 0);

      for (int n = 0; n < 40; n++) begin
         op = seq16_op_t'($urandom_range(0, 4));
         a  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : 16'($urandom);
         run_op(op, a, b, $urandom_range(0, 3));
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
